// File: rtl/voice_harmonic_scheduler.sv
// Additive-synthesis frame scheduler: 4 voices x 6 harmonics share one wavetable ROM,
// one FETCH/ACC pair per slot, mixed result saturated to 16 bits once per sample tick.
module voice_harmonic_scheduler (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        sample_clk,
    input  logic [23:0] freq0,
    input  logic [23:0] freq1,
    input  logic [23:0] freq2,
    input  logic [23:0] freq3,
    input  logic [5:0]  harm_en,
    output logic [9:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {StIdle, StFetch, StAcc, StDone} state_e;

    state_e             state_q;
    logic               sc_q, sc_prev_q;
    logic [23:0]        freq_q [4];
    logic [23:0]        phase_q [4];
    logic [5:0]         harm_q;
    logic [1:0]         voice_q;
    logic [2:0]         harm_idx_q;
    logic signed [20:0] acc_q;
    logic [9:0]         rom_addr_q;
    logic [15:0]        data_out_q;
    logic               data_valid_q, busy_q, overrun_q;

    logic               tick;
    logic               last_slot;
    logic [1:0]         nxt_voice;
    logic [2:0]         nxt_harm;
    logic [9:0]         nxt_addr;
    logic [1:0]         shamt;
    logic               slot_en;
    logic signed [20:0] rom_ext;
    logic signed [20:0] term;
    logic signed [20:0] acc_d;
    logic [15:0]        data_out_d;

    // Wavetable index = top 10 bits of the harmonic phase, wrapping mod 2^24.
    function automatic logic [9:0] slot_addr(input logic [23:0] phase, input logic [2:0] h);
        return 10'((phase * {21'd0, h}) >> 14);
    endfunction

    assign tick = sc_q & ~sc_prev_q;

    always_comb begin
        last_slot = (voice_q == 2'd3) && (harm_idx_q == 3'd5);
        if (harm_idx_q == 3'd5) begin
            nxt_voice = voice_q + 2'd1;
            nxt_harm  = 3'd0;
        end else begin
            nxt_voice = voice_q;
            nxt_harm  = harm_idx_q + 3'd1;
        end
        nxt_addr = slot_addr(phase_q[nxt_voice], nxt_harm + 3'd1);
    end

    always_comb begin
        unique case (harm_idx_q)
            3'd0:       shamt = 2'd0;
            3'd1, 3'd2: shamt = 2'd1;
            default:    shamt = 2'd2;
        endcase
        slot_en = harm_q[harm_idx_q] && (freq_q[voice_q] != 24'd0);
        rom_ext = {{5{rom_data[15]}}, rom_data};
        term    = slot_en ? (rom_ext >>> shamt) : 21'sd0;
        acc_d   = acc_q + term;
    end

    always_comb begin
        if (acc_q > 21'sd32767) begin
            data_out_d = 16'h7fff;
        end else if (acc_q < -21'sd32768) begin
            data_out_d = 16'h8000;
        end else begin
            data_out_d = acc_q[15:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= StIdle;
            sc_q         <= 1'b0;
            sc_prev_q    <= 1'b0;
            harm_q       <= '0;
            voice_q      <= '0;
            harm_idx_q   <= '0;
            acc_q        <= '0;
            rom_addr_q   <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                freq_q[i]  <= '0;
                phase_q[i] <= '0;
            end
        end else begin
            sc_q         <= sample_clk;
            sc_prev_q    <= sc_q;
            data_valid_q <= 1'b0;
            // A tick during a frame (DONE included) is dropped, only flagged.
            if (tick && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (tick) begin
                        freq_q[0]  <= freq0;
                        freq_q[1]  <= freq1;
                        freq_q[2]  <= freq2;
                        freq_q[3]  <= freq3;
                        harm_q     <= harm_en;
                        acc_q      <= '0;
                        voice_q    <= '0;
                        harm_idx_q <= '0;
                        rom_addr_q <= phase_q[0][23:14];
                        busy_q     <= 1'b1;
                        state_q    <= StFetch;
                    end
                end
                StFetch: begin
                    state_q <= StAcc;
                end
                StAcc: begin
                    acc_q <= acc_d;
                    if (last_slot) begin
                        state_q <= StDone;
                    end else begin
                        voice_q    <= nxt_voice;
                        harm_idx_q <= nxt_harm;
                        rom_addr_q <= nxt_addr;
                        state_q    <= StFetch;
                    end
                end
                StDone: begin
                    data_out_q   <= data_out_d;
                    data_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= StIdle;
                    // Silent voices restart from phase 0 on their next note.
                    for (int i = 0; i < 4; i++) begin
                        phase_q[i] <= (freq_q[i] != 24'd0) ? phase_q[i] + freq_q[i] : 24'd0;
                    end
                end
            endcase
        end
    end

    assign rom_addr   = rom_addr_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/voice_harmonic_scheduler.md
VOICE_HARMONIC_SCHEDULER -- requirements
Module: voice_harmonic_scheduler

Interface
REQ-001 SHALL have port: Clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port: Reset  input  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
REQ-003 SHALL have port: sample_clk  input  1  raw audio sample-rate level; rising edge is detected internally.
REQ-004 SHALL have ports: freq0..freq3  input  24 each  per-voice phase increment from key mapper; 0 = voice off.
REQ-005 SHALL have port: harm_en  input  6  bit h-1 enables harmonic h (1..6) for all voices.
REQ-006 SHALL have port: rom_addr  output  10  address to shared wavetable ROM; ROM read latency exactly 1 cycle.
REQ-007 SHALL have port: rom_data  input  16  signed ROM sample for the address driven the previous cycle.
REQ-008 SHALL have port: data_out  output  16  signed mixed sample, held between frames.
REQ-009 SHALL have port: data_valid  output  1  one-cycle pulse when data_out updates.
REQ-010 SHALL have port: busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-011 SHALL have port: overrun  output  1  sticky flag, set when a tick arrives while busy.

Function
REQ-012 SHALL time-share one ROM across 24 slots (voice v 0..3, harmonic h 1..6), in the order v-major, h-minor: (0,1),(0,2)..(0,6),(1,1)..(3,6).
REQ-013 SHALL implement the FSM states IDLE, FETCH, ACC and DONE.
REQ-014 IDLE -> FETCH on the cycle after sample_clk is sampled 1 having been 0 the previous cycle (tick).
REQ-015 On tick acceptance SHALL latch freq0..3 and harm_en; input changes mid-frame SHALL NOT affect that frame.
REQ-016 SHALL clear the accumulator at frame start.
REQ-017 FETCH: SHALL drive rom_addr = bits[23:14] of (phase_v * h) mod 2^24; next state is ACC.
REQ-018 ACC: SHALL add (rom_data >>> shift_h) to the accumulator, where shift_h = 0,1,1,2,2,2 for h = 1..6 (arithmetic shift).
REQ-019 ACC: SHALL add 0 instead if the slot's harm_en bit is 0 or its latched freq_v = 0.
REQ-020 ACC: SHALL go to FETCH of the next slot, or to DONE after slot (3,6).
REQ-021 Disabled slots SHALL still consume their FETCH/ACC cycles; frame timing is fixed at 48 slot cycles.
REQ-022 The accumulator SHALL be 21-bit signed, which cannot overflow for 24 terms.
REQ-023 DONE: SHALL register data_out = accumulator saturated to [-32768, 32767] and pulse data_valid.
REQ-024 DONE: SHALL update phase_v = (phase_v + freq_v) mod 2^24 for each voice with freq_v != 0.
REQ-025 DONE: SHALL set phase_v = 0 for each voice with freq_v = 0, so a note restarts at phase 0.
REQ-026 DONE: next state SHALL be IDLE.
REQ-027 Latency: tick sampled at cycle t -> FETCH at t+1 -> DONE at t+49 -> data_out/data_valid visible at t+50.
REQ-028 A tick detected while busy SHALL be ignored (no restart, frame completes normally) and SHALL set overrun.
REQ-029 A tick coincident with DONE counts as busy.
REQ-030 rom_addr SHALL hold its last value outside FETCH.
REQ-031 busy SHALL be high from FETCH of slot (0,1) through DONE inclusive.

Reset
REQ-032 While Reset = 0 at a clock edge: state SHALL go to IDLE, and data_out, data_valid, busy, overrun, rom_addr, the accumulator and all 4 phase registers SHALL clear to 0.
REQ-033 The sample_clk edge-detect history SHALL clear to 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no data_valid pulse.
REQ-035 After reset deasserts, sample_clk already high SHALL count as a tick on the first cycle it is sampled.

Verification
REQ-036 Reset check: Reset low 2 cycles with sample_clk toggling -> all outputs 0 and busy 0 throughout.
REQ-037 Single voice: freq0=0x004000, others 0, harm_en=6'b000001, ROM model returns 0x1000 -> data_out=0x1000 with data_valid exactly at t+50; rom_addr for slot (0,1) = 0, 0x001, 0x002 on ticks 1, 2, 3.
REQ-038 Harmonic addressing: freq1=0x100000, harm_en=6'b111111, after 2 ticks (phase1=0x200000) -> slot (1,3) rom_addr=0x180 and slot (1,6) rom_addr=0x300.
REQ-039 Saturation: all freqs non-zero, harm_en all ones, ROM returns 0x7FFF -> data_out=0x7FFF; ROM returns 0x8000 -> data_out=0x8000.
REQ-040 Overrun: second sample_clk rising edge at t+20 -> no restart, data_valid still at t+50, overrun=1 and sticky until reset.
REQ-041 Reset mid-frame: Reset low at t+30 -> no data_valid; after release, the next tick produces data_out computed from phase 0.
